// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_e;

   localparam int DM_LANES = 4;
   localparam logic [DM_LANES-1:0] W_EB_NONE = 4'b1111;

   // Any cleared write-enable bit turns the request into a write.
   function automatic logic is_write(input logic [DM_LANES-1:0] w_eb);
      return (w_eb != W_EB_NONE);
   endfunction

endpackage

// File: rtl/dm_sram_responder_if.sv
// DM request/response bundle between the MEM stage and the responder.
// Latency: n/a (wires only).
// Backpressure: requester holds chip_select while DM_busy is high.
interface dm_sram_responder_if #(
   parameter int ADDR_WIDTH = 16
) ();
   import dm_pkg::*;

   logic                  chip_select;
   logic [DM_LANES-1:0]   w_eb;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           DM_in;
   logic [31:0]           DM_out;
   logic                  DM_valid;
   logic                  DM_busy;

   modport master (
      output chip_select, w_eb, addr, DM_in,
      input  DM_out, DM_valid, DM_busy
   );

   modport slave (
      input  chip_select, w_eb, addr, DM_in,
      output DM_out, DM_valid, DM_busy
   );

endinterface

// File: rtl/dm_byte_array.sv
// Word storage with per-lane write enables and one synchronous read port.
// Latency: write lands at the clock edge; read data appears after the edge with rd_en.
// Backpressure: none; one write and one read may be issued every cycle.
module dm_byte_array #(
   parameter int DW = 32,
   parameter int AW = 14
) (
   input  logic              clk,
   input  logic [DW/8-1:0]   we,
   input  logic [AW-1:0]     wr_idx,
   input  logic [DW-1:0]     wr_dat,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_idx,
   output logic [DW-1:0]     rd_dat
);

   localparam int LANES = DW / 8;
   localparam int DEPTH = 2 ** AW;

   // Contents are deliberately never reset so data survives a core reset.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_dat_q;
   logic [DW-1:0] rd_dat_d;

   // Read register only moves on a read strobe, otherwise it holds.
   always_comb begin
      rd_dat_d = rd_dat_q;
      if (rd_en) begin
         rd_dat_d = mem[rd_idx];
      end
   end

   // Lane-masked write and registered read (read-before-write on collision).
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (we[l]) begin
            mem[wr_idx][l*8 +: 8] <= wr_dat[l*8 +: 8];
         end
      end
      rd_dat_q <= rd_dat_d;
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/dm_sram_responder.sv
// DM responder: lane-masked zero-latency writes, reads returned after READ_LAT cycles.
// Latency: write 0 cycles; read response (DM_valid pulse) READ_LAT cycles after accept.
// Backpressure: DM_busy high while a read waits; requests seen then are dropped.
// Optional access counters enabled by defining DM_ACCESS_CNT_EN.
module dm_sram_responder
   import dm_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int READ_LAT   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   dm_sram_responder_if.slave   dm
`ifdef DM_ACCESS_CNT_EN
   ,
   output logic [31:0]          rd_cnt,
   output logic [31:0]          wr_cnt,
   output logic [31:0]          stall_cnt
`endif
);

   localparam int AW = ADDR_WIDTH - 2;
   // WAIT counts down to zero, so it is loaded with READ_LAT-2.
   localparam logic [2:0] CNT_INIT = 3'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

   if (READ_LAT < 1 || READ_LAT > 8) begin : g_bad_lat
      $error("dm_sram_responder: READ_LAT must be in 1..8");
   end

   dm_state_e      state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic [AW-1:0]  word_q, word_d;
   logic           resp_seen_q, resp_seen_d;

   logic                   busy;
   logic                   rd_acc;
   logic                   wr_acc;
   logic [AW-1:0]          req_idx;
   logic                   rd_en;
   logic [AW-1:0]          rd_idx;
   logic [DM_LANES-1:0]    arr_we;
   logic [DATA_WIDTH-1:0]  rd_dat;
   logic                   unused_addr_lsb;

   // Byte offset bits never select anything; the word index wraps naturally.
   assign req_idx         = dm.addr[ADDR_WIDTH-1:2];
   assign unused_addr_lsb = ^dm.addr[1:0];

   assign busy   = (state_q == WAIT);
   assign rd_acc = dm.chip_select && !busy && !is_write(dm.w_eb);
   assign wr_acc = dm.chip_select && !busy &&  is_write(dm.w_eb);
   assign arr_we = wr_acc ? ~dm.w_eb : '0;

   // Read sequencing: accept, optional countdown, then a one-cycle response.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      rd_en       = 1'b0;
      rd_idx      = word_q;
      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (rd_acc) begin
               if (READ_LAT == 1) begin
                  // Array is read on the accepting edge itself.
                  state_d = RESP;
                  rd_en   = 1'b1;
                  rd_idx  = req_idx;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
                  word_d  = req_idx;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = RESP;
               rd_en   = 1'b1;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      resp_seen_d = resp_seen_q | rd_en;
   end

   // State register; reset aborts any read in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         word_q      <= '0;
         resp_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         resp_seen_q <= resp_seen_d;
      end
   end

   dm_byte_array #(
      .DW (DATA_WIDTH),
      .AW (AW)
   ) u_array (
      .clk    (clk),
      .we     (arr_we),
      .wr_idx (req_idx),
      .wr_dat (dm.DM_in),
      .rd_en  (rd_en),
      .rd_idx (rd_idx),
      .rd_dat (rd_dat)
   );

   // The array read register does not reset, so gate it until a response lands.
   assign dm.DM_out   = resp_seen_q ? rd_dat : '0;
   assign dm.DM_valid = (state_q == RESP);
   assign dm.DM_busy  = busy;

`ifdef DM_ACCESS_CNT_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Free-running wrap-around access statistics.
   always_comb begin
      rd_cnt_d    = rd_cnt_q    + {31'd0, rd_acc};
      wr_cnt_d    = wr_cnt_q    + {31'd0, wr_acc};
      stall_cnt_d = stall_cnt_q + {31'd0, (dm.chip_select && busy)};
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt_q    <= 32'd0;
         wr_cnt_q    <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign rd_cnt    = rd_cnt_q;
   assign wr_cnt    = wr_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dm_sram_responder.sv
// Bench for dm_sram_responder: READ_LAT=2 and READ_LAT=1 instances fed identical requests.
// Latency: each model predicts busy per cycle and the cycle of every read response.
// Backpressure: model drops requests that land in a predicted busy cycle.
module tb_dm_sram_responder;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic clk;
   logic rst;

   logic        cs_r;
   logic [3:0]  web_r;
   logic [15:0] addr_r;
   logic [31:0] din_r;

   dm_sram_responder_if #(.ADDR_WIDTH(16)) dm2 ();
   dm_sram_responder_if #(.ADDR_WIDTH(16)) dm1 ();

   assign dm2.chip_select = cs_r;
   assign dm2.w_eb        = web_r;
   assign dm2.addr        = addr_r;
   assign dm2.DM_in       = din_r;
   assign dm1.chip_select = cs_r;
   assign dm1.w_eb        = web_r;
   assign dm1.addr        = addr_r;
   assign dm1.DM_in       = din_r;

`ifdef DM_ACCESS_CNT_EN
   logic [31:0] rd_cnt_o [2];
   logic [31:0] wr_cnt_o [2];
   logic [31:0] stall_cnt_o [2];
`endif

   dm_sram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .READ_LAT(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .dm  (dm2)
`ifdef DM_ACCESS_CNT_EN
      ,
      .rd_cnt    (rd_cnt_o[0]),
      .wr_cnt    (wr_cnt_o[0]),
      .stall_cnt (stall_cnt_o[0])
`endif
   );

   dm_sram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .READ_LAT(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .dm  (dm1)
`ifdef DM_ACCESS_CNT_EN
      ,
      .rd_cnt    (rd_cnt_o[1]),
      .wr_cnt    (wr_cnt_o[1]),
      .stall_cnt (stall_cnt_o[1])
`endif
   );

   logic [31:0] out_o   [2];
   logic        valid_o [2];
   logic        busy_o  [2];
   assign out_o[0]   = dm2.DM_out;
   assign out_o[1]   = dm1.DM_out;
   assign valid_o[0] = dm2.DM_valid;
   assign valid_o[1] = dm1.DM_valid;
   assign busy_o[0]  = dm2.DM_busy;
   assign busy_o[1]  = dm1.DM_busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state, index 0 = READ_LAT 2, index 1 = READ_LAT 1.
   int          lat [2] = '{2, 1};
   logic [31:0] mem [2][64];
   int          busy_left [2];
   logic        exp_busy_now [2];
   exp_t        exp_q [2][$];
   int          rd_m [2];
   int          wr_m [2];
   int          stall_m [2];

   int cyc;
   int n_cmp;
   int n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One bus cycle: predict acceptance per instance, then let the edge happen.
   task automatic step(input logic cs, input logic [3:0] web, input logic [15:0] a,
                       input logic [31:0] d);
      int   w;
      logic bz;
      cs_r   = cs;
      web_r  = web;
      addr_r = a;
      din_r  = d;
      w      = int'(a[7:2]);
      for (int i = 0; i < 2; i++) begin
         bz = (busy_left[i] > 0);
         exp_busy_now[i] = bz;
         if (cs && bz) stall_m[i]++;
         if (bz) busy_left[i]--;
         if (cs && !bz) begin
            if (web != 4'hF) begin
               for (int l = 0; l < 4; l++)
                  if (!web[l]) mem[i][w][l*8 +: 8] = d[l*8 +: 8];
               wr_m[i]++;
            end else begin
               exp_q[i].push_back('{data: mem[i][w], due: cyc + lat[i]});
               busy_left[i] = lat[i] - 1;
               rd_m[i]++;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 4'hF, 16'h0, 32'h0);
   endtask

   // Asynchronous reset in the middle of a cycle; any pending response is lost.
   task automatic do_reset();
      rst  = 1'b1;
      cs_r = 1'b0;
      for (int i = 0; i < 2; i++) begin
         busy_left[i]    = 0;
         exp_busy_now[i] = 1'b0;
         exp_q[i].delete();
         rd_m[i]    = 0;
         wr_m[i]    = 0;
         stall_m[i] = 0;
      end
      #1;
      chk("rst_out_lat2", out_o[0], 32'h0);
      chk("rst_out_lat1", out_o[1], 32'h0);
      chk("rst_valid_lat2", {31'd0, valid_o[0]}, 32'h0);
      chk("rst_valid_lat1", {31'd0, valid_o[1]}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
   endtask

   // Monitor: busy every cycle, and every response checked for data and timing.
   always @(negedge clk) begin : mon
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (busy_o[i] !== exp_busy_now[i]) begin
            n_fail++;
            $display("FAIL busy[%0d]: got %b expected %b (cycle %0d)", i, busy_o[i],
                     exp_busy_now[i], cyc);
         end
         if (valid_o[i] === 1'b1) begin
            n_cmp++;
            if (exp_q[i].size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_valid[%0d]: got valid expected none (cycle %0d)", i, cyc);
            end else begin
               e = exp_q[i].pop_front();
               if (out_o[i] !== e.data || cyc != e.due) begin
                  n_fail++;
                  $display("FAIL resp[%0d]: got 0x%08h at cycle %0d expected 0x%08h at cycle %0d",
                           i, out_o[i], cyc, e.data, e.due);
               end
            end
         end else if (exp_q[i].size() > 0 && exp_q[i][0].due <= cyc) begin
            n_cmp++;
            n_fail++;
            e = exp_q[i].pop_front();
            $display("FAIL missing_valid[%0d]: got none expected 0x%08h at cycle %0d",
                     i, e.data, e.due);
         end
      end
   end

   initial begin
      rst    = 1'b1;
      cs_r   = 1'b0;
      web_r  = 4'hF;
      addr_r = 16'h0;
      din_r  = 32'h0;
      cyc    = 0;
      n_cmp  = 0;
      n_fail = 0;
      for (int i = 0; i < 2; i++) begin
         busy_left[i] = 0; exp_busy_now[i] = 1'b0;
         rd_m[i] = 0; wr_m[i] = 0; stall_m[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_lat2", out_o[0], 32'h0);
      chk("reset_out_lat1", out_o[1], 32'h0);
      rst = 1'b0;

      // Preload the window used by the bench with full-word writes.
      for (int w = 0; w < 64; w++) step(1'b1, 4'h0, 16'(w * 4), $urandom);

      // Full-word write then read.
      step(1'b1, 4'h0, 16'h0010, 32'hDEADBEEF);
      step(1'b1, 4'hF, 16'h0010, 32'h0);
      idle(3);

      // Lane-masked writes.
      step(1'b1, 4'h0, 16'h0020, 32'h11223344);
      step(1'b1, 4'b1101, 16'h0020, 32'h0000AA00);
      step(1'b1, 4'hF, 16'h0020, 32'h0);
      idle(2);
      step(1'b1, 4'b0011, 16'h0022, 32'h55660000);
      step(1'b1, 4'hF, 16'h0021, 32'h0);
      idle(2);

      // Write issued while busy is dropped on the multi-cycle instance.
      step(1'b1, 4'h0, 16'h0030, 32'h0);
      step(1'b1, 4'hF, 16'h0010, 32'h0);
      step(1'b1, 4'h0, 16'h0030, 32'hFFFFFFFF);
      idle(1);
      step(1'b1, 4'hF, 16'h0030, 32'h0);
      idle(2);
      step(1'b1, 4'h0, 16'h0030, 32'hFFFFFFFF);
      step(1'b1, 4'hF, 16'h0030, 32'h0);
      idle(2);

      // Back-to-back reads.
      step(1'b1, 4'h0, 16'h0004, 32'd1);
      step(1'b1, 4'h0, 16'h0008, 32'd2);
      step(1'b1, 4'hF, 16'h0004, 32'h0);
      step(1'b1, 4'hF, 16'h0008, 32'h0);
      idle(3);

      // Held request: one stall cycle on the multi-cycle instance.
      step(1'b1, 4'hF, 16'h0020, 32'h0);
      step(1'b1, 4'h0, 16'h0040, 32'hCAFEF00D);
      step(1'b1, 4'h0, 16'h0040, 32'hCAFEF00D);
      idle(2);

      // Reset during the wait, then the array still holds its data.
      step(1'b1, 4'hF, 16'h0010, 32'h0);
      do_reset();
      idle(2);
      step(1'b1, 4'hF, 16'h0010, 32'h0);
      idle(3);

      // Randomised traffic.
      for (int k = 0; k < 800; k++) begin
         logic [3:0] web;
         web = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         step($urandom_range(0, 3) != 0, web, 16'($urandom_range(0, 255)), $urandom);
      end
      idle(12);

      for (int i = 0; i < 2; i++) chk("drain", 32'(exp_q[i].size()), 32'h0);
`ifdef DM_ACCESS_CNT_EN
      for (int i = 0; i < 2; i++) begin
         chk("rd_cnt", rd_cnt_o[i], 32'(rd_m[i]));
         chk("wr_cnt", wr_cnt_o[i], 32'(wr_m[i]));
         chk("stall_cnt", stall_cnt_o[i], 32'(stall_m[i]));
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
